// File: rtl/dice_round_ctrl.sv
// dice_round_ctrl: round sequencer for the two-player dice game.
// Turns debounced button pulses into periodic roll strobes for the two dice
// generators. Latches each player's final die, compares the dice, keeps the
// per-player scores and declares the match winner.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   btn1, btn2        1-cycle debounced player button pulses
//   dice1, dice2      generator outputs, 0..9 (larger values clamp to 9)
//   roll1, roll2      1-cycle roll strobes to generator 1 / 2
//   finish            1-cycle pulse in the first RESULT cycle
//   winner            last round: 00 none, 01 P1, 10 P2, 11 tie
//   score1, score2    round wins, saturating at WIN_SCORE
//   game_over         high while in GAME_OVER
//   state_o           display code: 0 IDLE, 1 P1_ROLL, 2 P1_SETTLE, 3 P2_WAIT,
//                     4 P2_ROLL, 5 P2_SETTLE, 6 COMPARE/RESULT, 7 GAME_OVER
//
// Optional feature macro: DICE_CTRL_AUTO_STOP_EN. When it is defined, each roll
// phase stops by itself after MAX_TICKS strobes. MAX_TICKS exists only in that
// build.
module dice_round_ctrl #(
    parameter int unsigned TICK_DIV    = 100,
    parameter int unsigned SETTLE_CYC  = 2,
    parameter int unsigned RESULT_HOLD = 1000,
    parameter int unsigned WIN_SCORE   = 3
`ifdef DICE_CTRL_AUTO_STOP_EN
    ,
    parameter int unsigned MAX_TICKS   = 50
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn1,
    input  logic       btn2,
    input  logic [3:0] dice1,
    input  logic [3:0] dice2,
    output logic       roll1,
    output logic       roll2,
    output logic       finish,
    output logic [1:0] winner,
    output logic [3:0] score1,
    output logic [3:0] score2,
    output logic       game_over,
    output logic [2:0] state_o
);

    localparam int unsigned CNT_MAX = (RESULT_HOLD > TICK_DIV) ? RESULT_HOLD : TICK_DIV;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_P1_ROLL, S_P1_SETTLE, S_P2_WAIT, S_P2_ROLL,
        S_P2_SETTLE, S_COMPARE, S_RESULT, S_GAME_OVER
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             roll1_q, roll1_d, roll2_q, roll2_d, finish_q, finish_d;
    logic [1:0]       winner_q, winner_d;
    logic [3:0]       score1_q, score1_d, score2_q, score2_d;
    logic [3:0]       d1_q, d1_d, d2_q, d2_d;
    logic             game_over_q, game_over_d;
    logic [2:0]       state_o_q, state_o_d;

    logic tick_last_c, in_roll_c, stop_c, auto_stop_c;

    function automatic logic [3:0] clamp9(input logic [3:0] v);
        return (v > 4'd9) ? 4'd9 : v;
    endfunction

    function automatic logic [2:0] disp_code(input state_t s);
        case (s)
            S_IDLE:      return 3'd0;
            S_P1_ROLL:   return 3'd1;
            S_P1_SETTLE: return 3'd2;
            S_P2_WAIT:   return 3'd3;
            S_P2_ROLL:   return 3'd4;
            S_P2_SETTLE: return 3'd5;
            S_GAME_OVER: return 3'd7;
            default:     return 3'd6;
        endcase
    endfunction

    assign tick_last_c = (cnt_q == CNT_W'(TICK_DIV - 1));
    assign in_roll_c   = (state_q == S_P1_ROLL) || (state_q == S_P2_ROLL);
    // Only the active player's button can stop a roll.
    assign stop_c      = ((state_q == S_P1_ROLL) && btn1) ||
                         ((state_q == S_P2_ROLL) && btn2) || auto_stop_c;

`ifdef DICE_CTRL_AUTO_STOP_EN
    localparam int unsigned STRB_W = $clog2(MAX_TICKS + 1);
    logic [STRB_W-1:0] strb_q, strb_d;

    // Stop in the cycle the MAX_TICKS-th strobe is visible, so it still lies inside ROLL.
    assign auto_stop_c = in_roll_c && (strb_q == STRB_W'(MAX_TICKS));

    // Strobes issued in the current roll phase; cleared whenever not rolling.
    always_comb begin
        strb_d = '0;
        if (in_roll_c && !stop_c) begin
            strb_d = strb_q + STRB_W'(tick_last_c);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) strb_q <= '0;
        else     strb_q <= strb_d;
    end
`else
    assign auto_stop_c = 1'b0;
`endif

    // Next-state and registered-output logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = '0;
        roll1_d  = 1'b0;
        roll2_d  = 1'b0;
        finish_d = 1'b0;
        winner_d = winner_q;
        score1_d = score1_q;
        score2_d = score2_q;
        d1_d     = d1_q;
        d2_d     = d2_q;

        case (state_q)
            S_IDLE: begin
                if (btn1) state_d = S_P1_ROLL;
            end
            S_P1_ROLL, S_P2_ROLL: begin
                if (stop_c) begin
                    state_d = (state_q == S_P1_ROLL) ? S_P1_SETTLE : S_P2_SETTLE;
                end else begin
                    cnt_d   = tick_last_c ? '0 : cnt_q + CNT_W'(1);
                    roll1_d = tick_last_c && (state_q == S_P1_ROLL);
                    roll2_d = tick_last_c && (state_q == S_P2_ROLL);
                end
            end
            S_P1_SETTLE: begin
                if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
                    d1_d    = clamp9(dice1);
                    state_d = S_P2_WAIT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_P2_WAIT: begin
                if (btn2) state_d = S_P2_ROLL;
            end
            S_P2_SETTLE: begin
                if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
                    d2_d    = clamp9(dice2);
                    state_d = S_COMPARE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_COMPARE: begin
                state_d  = S_RESULT;
                finish_d = 1'b1;
                if (d1_q > d2_q) begin
                    winner_d = 2'b01;
                    if (score1_q < 4'(WIN_SCORE)) score1_d = score1_q + 4'd1;
                end else if (d2_q > d1_q) begin
                    winner_d = 2'b10;
                    if (score2_q < 4'(WIN_SCORE)) score2_d = score2_q + 4'd1;
                end else begin
                    winner_d = 2'b11;
                end
            end
            S_RESULT: begin
                if (cnt_q == CNT_W'(RESULT_HOLD - 1)) begin
                    state_d = ((score1_q == 4'(WIN_SCORE)) || (score2_q == 4'(WIN_SCORE)))
                              ? S_GAME_OVER : S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_GAME_OVER: begin
                if (btn1 && btn2) begin
                    state_d  = S_IDLE;
                    score1_d = 4'd0;
                    score2_d = 4'd0;
                    winner_d = 2'b00;
                end
            end
            default: state_d = S_IDLE;
        endcase

        game_over_d = (state_d == S_GAME_OVER);
        state_o_d   = disp_code(state_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            roll1_q     <= 1'b0;
            roll2_q     <= 1'b0;
            finish_q    <= 1'b0;
            winner_q    <= 2'b00;
            score1_q    <= 4'd0;
            score2_q    <= 4'd0;
            d1_q        <= 4'd0;
            d2_q        <= 4'd0;
            game_over_q <= 1'b0;
            state_o_q   <= 3'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            roll1_q     <= roll1_d;
            roll2_q     <= roll2_d;
            finish_q    <= finish_d;
            winner_q    <= winner_d;
            score1_q    <= score1_d;
            score2_q    <= score2_d;
            d1_q        <= d1_d;
            d2_q        <= d2_d;
            game_over_q <= game_over_d;
            state_o_q   <= state_o_d;
        end
    end

    assign roll1     = roll1_q;
    assign roll2     = roll2_q;
    assign finish    = finish_q;
    assign winner    = winner_q;
    assign score1    = score1_q;
    assign score2    = score2_q;
    assign game_over = game_over_q;
    assign state_o   = state_o_q;

endmodule
